// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch and data
// access; data wins ties, and a flushed fetch completes on the bus silently.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_rdy,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_rdy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq_for_if,
  output logic              stallreq_for_mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic                owner_data_q, owner_data_d;
  logic                drop_q, drop_d;
  logic                in_done;

  // Next-state, bus-register and response-register logic.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_d       = resp_q;
    owner_data_d = owner_data_q;
    drop_d       = drop_q;
    case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d     = DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = data_we;
          mem_sel_d   = data_sel;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
        end else if (inst_req && !flush) begin
          state_d    = INST;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_sel_d  = 4'b1111;
          mem_addr_d = inst_addr;
        end else begin
          state_d = IDLE;
        end
      end
      INST: begin
        // A flush in the ack cycle itself must still drop the result.
        drop_d = drop_q | flush;
        if (mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          resp_d       = mem_rdata;
          owner_data_d = 1'b0;
        end else begin
          state_d = INST;
        end
      end
      DATA: begin
        if (mem_ack) begin
          state_d      = DONE;
          mem_req_d    = 1'b0;
          resp_d       = mem_rdata;
          owner_data_d = 1'b1;
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 4'b0000;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      resp_q       <= {DATA_W{1'b0}};
      owner_data_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_q       <= resp_d;
      owner_data_q <= owner_data_d;
      drop_q       <= drop_d;
    end
  end

  assign in_done = (state_q == DONE);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // inst_rdy looks at the live flush so a flush in the DONE cycle still kills it.
  assign inst_rdy   = in_done & ~owner_data_q & ~drop_q & ~flush;
  assign data_rdy   = in_done & owner_data_q;
  assign inst_rdata = resp_q;
  assign data_rdata = resp_q;

  assign stallreq_for_if  = inst_req & ~inst_rdy;
  assign stallreq_for_mem = data_req & ~data_rdy;

endmodule
